// File: rtl/oled_pkg.sv
// Shared types and SPI constants for the OLED burst streamer and its helpers.
package oled_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    ZERO  = 2'd3
  } state_t;

  // SCLK idle levels for the common SPI modes
  localparam logic SPI_MODE0_CPOL = 1'b0;
  localparam logic SPI_MODE3_CPOL = 1'b1;

  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period timer for SPI bit timing: strobes at the end of each SCLK half
// and at the end of each full bit.
module spi_tick_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic bit_end,
  output logic phase
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // phase = 0 in the first half of a bit, 1 in the second
  always_ff @(posedge clk_100mhz) begin
    if (rst || clear) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (enable) begin
      if (cnt == CNT_LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign half_tick = enable && (cnt == CNT_LAST);
  assign bit_end   = half_tick && phase;

endmodule

// File: rtl/oled_burst_streamer.sv
// Sends a latched burst of up to MAX_BYTES bytes to an SPI OLED, MSB-first,
// with a D/C level per burst and an enforced CS-high gap between bursts.
module oled_burst_streamer
  import oled_pkg::*;
#(
  parameter int   MAX_BYTES = 16,
  parameter int   CLK_DIV   = 5,
  parameter logic CPOL      = SPI_MODE3_CPOL,
  parameter int   CS_GAP    = 4
) (
  input  logic                              clk_100mhz,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              abort,
  input  logic                              data_type_in,
  input  logic [$clog2(MAX_BYTES+1)-1:0]    byte_count_in,
  input  logic [MAX_BYTES*8-1:0]            send_bytes_in,
  output logic                              busy,
  output logic                              done,
  output logic                              aborted,
  output logic                              mosi,
  output logic                              cs,
  output logic                              sclk,
  output logic                              d_c
);

  localparam int BYTE_W = $clog2(MAX_BYTES + 1);
  localparam int PAY_W  = MAX_BYTES * 8;
  localparam int GAP_W  = $clog2(CS_GAP + 1);
  localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

  state_t             state;
  logic [PAY_W-1:0]   shreg;
  logic [2:0]         bit_cnt;
  logic [BYTE_W-1:0]  byte_cnt;
  logic [BYTE_W-1:0]  byte_last;
  logic [GAP_W-1:0]   gap_cnt;
  logic [BYTE_W-1:0]  count_clamped;
  logic               accept;
  logic               abort_hit;
  logic               last_bit;
  logic               half_tick;
  logic               bit_end;
  logic               phase;

  assign accept        = (state == IDLE) && start;
  assign abort_hit     = (state == SHIFT) && abort;
  assign count_clamped = (byte_count_in > BYTE_W'(MAX_BYTES)) ? BYTE_W'(MAX_BYTES)
                                                              : byte_count_in;
  assign last_bit      = bit_end && (bit_cnt == LAST_BIT) && (byte_cnt == byte_last);

  spi_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .clear      (accept || abort_hit),
    .enable     (state == SHIFT),
    .half_tick  (half_tick),
    .bit_end    (bit_end),
    .phase      (phase)
  );

  // Payload is preloaded so byte 0 bit 7 is on mosi in the first SHIFT cycle;
  // the shift register then always holds the next bit at its top.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state     <= IDLE;
      cs        <= 1'b1;
      sclk      <= CPOL;
      mosi      <= 1'b0;
      d_c       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      byte_last <= '0;
      gap_cnt   <= '0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            d_c  <= data_type_in;
            busy <= 1'b1;
            if (count_clamped == '0) begin
              done  <= 1'b1;
              state <= ZERO;
            end else begin
              state     <= SHIFT;
              cs        <= 1'b0;
              sclk      <= CPOL;
              mosi      <= send_bytes_in[PAY_W-1];
              shreg     <= send_bytes_in << 1;
              bit_cnt   <= '0;
              byte_cnt  <= '0;
              byte_last <= count_clamped - BYTE_W'(1);
            end
          end
        end

        ZERO: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        SHIFT: begin
          // Abort wins over a burst that would complete this same cycle
          if (abort || last_bit) begin
            aborted <= abort;
            done    <= ~abort;
            cs      <= 1'b1;
            sclk    <= CPOL;
            mosi    <= 1'b0;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (half_tick && !phase) begin
            sclk <= ~CPOL;
          end else if (bit_end) begin
            sclk    <= CPOL;
            mosi    <= shreg[PAY_W-1];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) begin
              byte_cnt <= byte_cnt + BYTE_W'(1);
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/oled_burst_streamer.md
OLED_BURST_STREAMER -- requirements
Module: oled_burst_streamer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 16: maximum bytes per burst, at least 1.
REQ-002 SHALL have parameter CLK_DIV, default 5: clk_100mhz cycles per SCLK half-period, at least 1; the default gives 10 MHz SCLK.
REQ-003 SHALL have parameter CPOL, default 1: SCLK idle level.
REQ-004 SHALL have parameter CS_GAP, default 4: minimum cycles CS stays high between bursts, at least 1.
REQ-005 SHALL have port clk_100mhz, input, 1: system clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: burst request; a single-cycle pulse.
REQ-008 SHALL have port abort, input, 1: terminate the active burst.
REQ-009 SHALL have port data_type_in, input, 1: D/C level for the burst (1 = data, 0 = command).
REQ-010 SHALL have port byte_count_in, input, $clog2(MAX_BYTES+1): number of bytes to send.
REQ-011 SHALL have port send_bytes_in, input, MAX_BYTES*8: payload; byte 0 = bits [MAX_BYTES*8-1 -: 8].
REQ-012 SHALL have port busy, output, 1: high from the cycle after an accepted start through the end of the CS gap.
REQ-013 SHALL have port done, output, 1: one-cycle pulse on normal burst completion.
REQ-014 SHALL have port aborted, output, 1: one-cycle pulse when a burst is aborted.
REQ-015 SHALL have ports mosi, cs, sclk and d_c, outputs, 1 each: SPI lines plus the OLED D/C line.

Function
REQ-016 SHALL accept start only in IDLE; start while busy is ignored, with no queueing.
REQ-017 SHALL, on an accepted start, latch data_type_in, byte_count_in and send_bytes_in; later input changes have no effect on that burst.
REQ-018 SHALL treat byte_count_in = 0 as an empty burst: done pulses the next cycle, and cs, sclk and mosi do not move.
REQ-019 SHALL treat byte_count_in > MAX_BYTES as MAX_BYTES.
REQ-020 SHALL implement states IDLE -> SHIFT -> GAP -> IDLE, with ZERO (one cycle) for empty bursts.
REQ-021 SHALL, in the cycle after an accepted start: drive cs low, set d_c to the latched value, and present bit 7 of byte 0 on mosi.
REQ-022 SHALL make each bit last 2*CLK_DIV cycles: sclk = CPOL for the first CLK_DIV cycles, ~CPOL for the next CLK_DIV.
REQ-023 SHALL change mosi only at bit boundaries; the slave samples on the first SCLK edge of each bit.
REQ-024 SHALL send bits MSB-first within each byte and bytes in ascending index order.
REQ-025 SHALL hold cs low for exactly count*16*CLK_DIV cycles, with no gaps between bytes.
REQ-026 SHALL, in the cycle after the last bit: raise cs, return sclk to CPOL, drive mosi 0, pulse done, and enter GAP.
REQ-027 SHALL keep GAP for CS_GAP cycles with busy high, then return to IDLE; start is accepted on the first IDLE cycle.
REQ-028 SHALL, on abort in SHIFT, in the next cycle: raise cs, return sclk to CPOL, drive mosi 0, pulse aborted (not done), and enter GAP.
REQ-029 SHALL ignore abort outside SHIFT.
REQ-030 SHALL give abort priority over burst completion when both occur in the same cycle.
REQ-031 SHALL hold d_c at its last value after a burst, changing only on the next accepted start.
REQ-032 SHALL use bit and byte counters sized from the parameters, with no wrap inside a burst.

Reset
REQ-033 SHALL, on rst, set state IDLE, cs = 1, sclk = CPOL, mosi = 0, d_c = 0, and busy, done and aborted = 0.
REQ-034 SHALL, on rst asserted mid-burst, take effect the next cycle (cs high, no done or aborted pulse); rst overrides start and abort.

Structure
REQ-035 SHALL place the state enum (IDLE, SHIFT, GAP, ZERO) and SPI mode constants in shared package oled_pkg.
REQ-036 SHALL instantiate one sub-module, spi_tick_gen: a CLK_DIV half-period counter emitting half-tick and bit-end strobes, cleared on start and abort.

Verification
REQ-037 SHALL cover: CLK_DIV=5, CPOL=1, count=1, byte 0xA5, d_c=1 -> cs low exactly 80 cycles, MOSI 1,0,1,0,0,1,0,1, done pulses once, d_c=1 throughout.
REQ-038 SHALL cover: count=3, bytes 0x12, 0x34, 0x56 -> 24 contiguous bits in order, cs low 240 cycles, exactly 24 SCLK edges leaving CPOL.
REQ-039 SHALL cover: count=0 -> done the next cycle, cs never low, busy high one cycle.
REQ-040 SHALL cover: abort at cycle 30 of a 2-byte burst -> cs high at cycle 31, aborted pulses, no done, busy low after 4 gap cycles.
REQ-041 SHALL cover: start held high every cycle -> bursts separated by cs-high gaps of at least CS_GAP cycles; mid-burst starts are ignored.
REQ-042 SHALL cover: rst mid-burst -> the next cycle shows cs = 1, sclk = CPOL, mosi = 0, busy = 0, and no done.
